// File: rtl/pong_pkg.sv
// Shared types and default colours for the game renderer and its helpers.
package pong_pkg;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef enum logic {
    FLASH_IDLE,
    FLASH_ON
  } flash_state_e;

  localparam logic [11:0] DEF_FG_RGB    = 12'hFFF;
  localparam logic [11:0] DEF_BG_RGB    = 12'h000;
  localparam logic [11:0] DEF_FLASH_RGB = 12'hF00;

endpackage

// File: rtl/rect_hit.sv
// Combinational half-open rectangle test: x in [x0, x0+W) and y in [y0, y0+H).
module rect_hit
  import pong_pkg::*;
#(
  parameter int W = 4,
  parameter int H = 20
) (
  input  coord_t x,
  input  coord_t y,
  input  coord_t x0,
  input  coord_t y0,
  output logic   hit
);

  logic [10:0] x_end;
  logic [10:0] y_end;
  logic        x_in;
  logic        y_in;

  // Sums are formed in 11 bits so a rectangle touching the 10-bit limit cannot wrap.
  always_comb begin
    x_end = {1'b0, x0} + 11'(W);
    y_end = {1'b0, y0} + 11'(H);
    x_in  = ({1'b0, x} >= {1'b0, x0}) && ({1'b0, x} < x_end);
    y_in  = ({1'b0, y} >= {1'b0, y0}) && ({1'b0, y} < y_end);
    hit   = x_in && y_in;
  end

endmodule

// File: rtl/game_renderer.sv
// Pipelined pong screen renderer: frame-latched positions, hit tests, centre net
// and a goal-flash background, producing registered RGB two cycles after (x, y, de).
module game_renderer
  import pong_pkg::*;
#(
  parameter int          WIDTH         = 640,
  parameter int          HEIGHT        = 480,
  parameter int          PADDLE_X      = 8,
  parameter int          PADDLE_WIDTH  = 4,
  parameter int          PADDLE_HEIGHT = 20,
  parameter int          BALL_SIZE     = 2,
  parameter int          NET_EN        = 1,
  parameter int          NET_WIDTH     = 2,
  parameter int          NET_DASH      = 8,
  parameter int          FLASH_FRAMES  = 30,
  parameter logic [11:0] FG_RGB        = DEF_FG_RGB,
  parameter logic [11:0] BG_RGB        = DEF_BG_RGB,
  parameter logic [11:0] FLASH_RGB     = DEF_FLASH_RGB
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       de,
  input  logic       frame_start,
  input  logic [9:0] p1_paddle_pos,
  input  logic [9:0] p2_paddle_pos,
  input  logic [9:0] ball_x_pos,
  input  logic [9:0] ball_y_pos,
  input  logic       goal,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       de_out
);

  localparam coord_t      PADDLE_MAX = coord_t'(HEIGHT - PADDLE_HEIGHT);
  localparam coord_t      BALL_X_MAX = coord_t'(WIDTH - BALL_SIZE);
  localparam coord_t      BALL_Y_MAX = coord_t'(HEIGHT - BALL_SIZE);
  localparam coord_t      P1_X0      = coord_t'(PADDLE_X);
  localparam coord_t      P2_X0      = coord_t'(WIDTH - PADDLE_X - PADDLE_WIDTH);
  localparam logic [10:0] NET_X0     = 11'(WIDTH / 2 - NET_WIDTH / 2);
  localparam logic [10:0] NET_X1     = 11'(WIDTH / 2 - NET_WIDTH / 2 + NET_WIDTH);
  localparam logic [10:0] NET_MASK   = 11'(NET_DASH - 1);
  localparam logic [10:0] NET_ON     = 11'(NET_DASH / 2);
  localparam int          CNT_W      = $clog2(FLASH_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLASH_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  coord_t p1s_q, p1s_d;
  coord_t p2s_q, p2s_d;
  coord_t bxs_q, bxs_d;
  coord_t bys_q, bys_d;

  logic p1_hit, p2_hit, ball_hit, net_hit;
  logic [3:0] hits_q, hits_d;
  logic       de1_q, de1_d;

  rgb12_t rgb_q, rgb_d;
  logic   de_out_q, de_out_d;

  flash_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Positions are clamped as they are latched so rendering never needs to range-check.
  always_comb begin
    p1s_d = p1s_q;
    p2s_d = p2s_q;
    bxs_d = bxs_q;
    bys_d = bys_q;
    if (frame_start) begin
      p1s_d = (p1_paddle_pos > PADDLE_MAX) ? PADDLE_MAX : p1_paddle_pos;
      p2s_d = (p2_paddle_pos > PADDLE_MAX) ? PADDLE_MAX : p2_paddle_pos;
      bxs_d = (ball_x_pos > BALL_X_MAX) ? BALL_X_MAX : ball_x_pos;
      bys_d = (ball_y_pos > BALL_Y_MAX) ? BALL_Y_MAX : ball_y_pos;
    end
  end

  rect_hit #(.W(PADDLE_WIDTH), .H(PADDLE_HEIGHT)) u_p1_hit (
    .x(x), .y(y), .x0(P1_X0), .y0(p1s_q), .hit(p1_hit)
  );

  rect_hit #(.W(PADDLE_WIDTH), .H(PADDLE_HEIGHT)) u_p2_hit (
    .x(x), .y(y), .x0(P2_X0), .y0(p2s_q), .hit(p2_hit)
  );

  rect_hit #(.W(BALL_SIZE), .H(BALL_SIZE)) u_ball_hit (
    .x(x), .y(y), .x0(bxs_q), .y0(bys_q), .hit(ball_hit)
  );

  // NET_DASH is a power of two, so the dash phase is just the low bits of y.
  always_comb begin
    net_hit = (NET_EN != 0)
           && ({1'b0, x} >= NET_X0) && ({1'b0, x} < NET_X1)
           && (({1'b0, y} & NET_MASK) < NET_ON);
    hits_d  = {p1_hit, p2_hit, ball_hit, net_hit};
    de1_d   = de;
  end

  always_comb begin
    rgb_d    = '0;
    de_out_d = de1_q;
    if (de1_q) begin
      if (|hits_q) begin
        rgb_d = rgb12_t'(FG_RGB);
      end else if (state_q == FLASH_ON) begin
        rgb_d = rgb12_t'(FLASH_RGB);
      end else begin
        rgb_d = rgb12_t'(BG_RGB);
      end
    end
  end

  // A goal (re)loads the full count and takes precedence over a same-cycle frame tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (goal) begin
      state_d = FLASH_ON;
      cnt_d   = CNT_LOAD;
    end else if (state_q == FLASH_ON && frame_start) begin
      if (cnt_q == CNT_ONE) begin
        state_d = FLASH_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1s_q    <= '0;
      p2s_q    <= '0;
      bxs_q    <= '0;
      bys_q    <= '0;
      hits_q   <= '0;
      de1_q    <= 1'b0;
      rgb_q    <= '0;
      de_out_q <= 1'b0;
      state_q  <= FLASH_IDLE;
      cnt_q    <= '0;
    end else begin
      p1s_q    <= p1s_d;
      p2s_q    <= p2s_d;
      bxs_q    <= bxs_d;
      bys_q    <= bys_d;
      hits_q   <= hits_d;
      de1_q    <= de1_d;
      rgb_q    <= rgb_d;
      de_out_q <= de_out_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

  assign red    = rgb_q.r;
  assign green  = rgb_q.g;
  assign blue   = rgb_q.b;
  assign de_out = de_out_q;

endmodule
